// File: rtl/rf_write_arbiter.sv
// Register-bank write-port arbiter: round-robin grant over NUM_REQ write-back
// sources, registered write stage, and a pending-write scoreboard for RAW hazards.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 32,
  parameter int NUM_REQ    = 3,
  localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      i_req_valid,
  input  logic [NUM_REQ-1:0][SELECT_WIDTH-1:0]    i_req_select,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      i_req_data,
  output logic [NUM_REQ-1:0]                      o_req_ready,
  input  logic                                    i_reserve_valid,
  input  logic [SELECT_WIDTH-1:0]                 i_reserve_select,
  output logic [NUM_REG-1:0]                      o_pending,
  output logic                                    o_write_enable,
  output logic [SELECT_WIDTH-1:0]                 o_write_select,
  output logic [DATA_WIDTH-1:0]                   o_write_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NREQ = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [NUM_REG-1:0] pending_q;
  logic [NUM_REG-1:0] pending_next;
  logic [NUM_REG-1:0] set_mask;
  logic [NUM_REG-1:0] clr_mask;

  // Search from ptr upward; the extra sum bit keeps (ptr + i) from wrapping
  // before the explicit modulo-NUM_REQ correction.
  always_comb begin : arbitrate
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    sum     = '0;
    idx     = '0;
    grant   = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(i);
      idx = PTR_W'((sum >= NREQ) ? sum - NREQ : sum);
      if (!xfer && i_req_valid[idx]) begin
        xfer    = 1'b1;
        gnt_idx = idx;
      end
    end
    if (rst) begin
      xfer = 1'b0;
    end
    if (xfer) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign o_req_ready = grant;
  assign ptr_next    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Register 0 is never reserved; a same-cycle reserve overrides the clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned r = 1; r < NUM_REG; r++) begin
      if (i_reserve_valid && (i_reserve_select == SELECT_WIDTH'(r))) begin
        set_mask[r] = 1'b1;
      end
      if (xfer && (i_req_select[gnt_idx] == SELECT_WIDTH'(r))) begin
        clr_mask[r] = 1'b1;
      end
    end
    pending_next = (pending_q & ~clr_mask) | set_mask;
  end

  assign o_pending = pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      o_write_enable <= 1'b0;
      o_write_select <= '0;
      o_write_data   <= '0;
      pending_q      <= '0;
    end else begin
      pending_q <= pending_next;
      if (xfer) begin
        ptr            <= ptr_next;
        o_write_select <= i_req_select[gnt_idx];
        o_write_data   <= i_req_data[gnt_idx];
        o_write_enable <= (i_req_select[gnt_idx] != '0);
      end else begin
        o_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written fairness and
// reset sequences, and random traffic against a behavioural model.
module tb_rf_write_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       valid;
  logic [2:0][4:0]  rsel;
  logic [2:0][31:0] rdat;
  logic [2:0]       o_req_ready;
  logic             rv;
  logic [4:0]       rs;
  logic [31:0]      o_pending;
  logic             o_write_enable;
  logic [4:0]       o_write_select;
  logic [31:0]      o_write_data;

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] got_ready;

  rf_write_arbiter #(.DATA_WIDTH(32), .NUM_REG(32), .NUM_REQ(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (valid),
    .i_req_select     (rsel),
    .i_req_data       (rdat),
    .o_req_ready      (o_req_ready),
    .i_reserve_valid  (rv),
    .i_reserve_select (rs),
    .o_pending        (o_pending),
    .o_write_enable   (o_write_enable),
    .o_write_select   (o_write_select),
    .o_write_data     (o_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  sel;
    logic [31:0] data;
    logic        rv;
    logic [4:0]  rs;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Caller drives inputs at the falling edge; ready is sampled mid-cycle,
  // registered outputs 1 time unit after the rising edge.
  task automatic step();
    #1;
    got_ready = o_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = '0;
    rv    = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  // Behavioural model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  initial begin
    logic [2:0] fair_exp[6];
    logic [2:0] drop_v[4];
    logic [2:0] drop_e[4];

    tbl[0]  = '{3'b010, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{3'b100, 5'd0, 32'h1234,     1'b0, 5'd0, 3'b100, 1'b0, 5'd0, 32'h1234,     32'h0};
    tbl[3]  = '{3'b000, 5'd0, 32'h0,        1'b1, 5'd7, 3'b000, 1'b0, 5'd0, 32'h1234,     32'h80};
    tbl[4]  = '{3'b001, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 3'b001, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h0};
    tbl[5]  = '{3'b000, 5'd0, 32'h0,        1'b1, 5'd7, 3'b000, 1'b0, 5'd7, 32'hA5A5A5A5, 32'h80};
    tbl[6]  = '{3'b010, 5'd7, 32'h77,       1'b1, 5'd7, 3'b010, 1'b1, 5'd7, 32'h77,       32'h80};
    tbl[7]  = '{3'b100, 5'd7, 32'h88,       1'b1, 5'd0, 3'b100, 1'b1, 5'd7, 32'h88,       32'h0};
    tbl[8]  = '{3'b000, 5'd0, 32'h0,        1'b1, 5'd0, 3'b000, 1'b0, 5'd7, 32'h88,       32'h0};
    tbl[9]  = '{3'b111, 5'd3, 32'h33,       1'b0, 5'd0, 3'b001, 1'b1, 5'd3, 32'h33,       32'h0};
    tbl[10] = '{3'b110, 5'd9, 32'h99,       1'b0, 5'd0, 3'b010, 1'b1, 5'd9, 32'h99,       32'h0};
    tbl[11] = '{3'b011, 5'd4, 32'h44,       1'b0, 5'd0, 3'b001, 1'b1, 5'd4, 32'h44,       32'h0};

    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
    fair_exp[3] = 3'b001; fair_exp[4] = 3'b010; fair_exp[5] = 3'b100;
    drop_v[0] = 3'b111; drop_v[1] = 3'b110; drop_v[2] = 3'b100; drop_v[3] = 3'b001;
    drop_e[0] = 3'b001; drop_e[1] = 3'b010; drop_e[2] = 3'b100; drop_e[3] = 3'b001;

    // Reset state, with requesters valid to show ready is held low
    rst   = 1'b1;
    valid = 3'b111;
    rsel  = '0;
    rdat  = '0;
    rv    = 1'b0;
    rs    = '0;
    #3;
    chk("reset_ready", o_req_ready, 3'b000);
    chk("reset_we",    o_write_enable, 1'b0);
    chk("reset_sel",   o_write_select, 5'd0);
    chk("reset_data",  o_write_data, 32'h0);
    chk("reset_pend",  o_pending, 32'h0);

    // Directed table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid = tbl[i].valid;
      for (int k = 0; k < 3; k++) begin
        rsel[k] = tbl[i].sel;
        rdat[k] = tbl[i].data;
      end
      rv = tbl[i].rv;
      rs = tbl[i].rs;
      step();
      chk($sformatf("tbl%0d_ready", i), got_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_we", i),    o_write_enable, tbl[i].e_we);
      chk($sformatf("tbl%0d_sel", i),   o_write_select, tbl[i].e_sel);
      chk($sformatf("tbl%0d_data", i),  o_write_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_pend", i),  o_pending, tbl[i].e_pend);
    end

    // Continuous contention from reset
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid = 3'b111;
      for (int k = 0; k < 3; k++) rsel[k] = 5'(k + 1);
      step();
      chk($sformatf("fair%0d_ready", c), got_ready, fair_exp[c]);
    end

    // Requesters drop after grant; requester 0 re-asserts at cycle 3
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      valid = drop_v[c];
      step();
      chk($sformatf("drop%0d_ready", c), got_ready, drop_e[c]);
    end

    // Asynchronous reset mid-operation
    do_reset();
    @(negedge clk);
    valid = 3'b001; rsel[0] = 5'd1; rdat[0] = 32'h11; rv = 1'b1; rs = 5'd3;
    step();
    @(negedge clk);
    valid = 3'b010; rsel[1] = 5'd2; rdat[1] = 32'h22; rv = 1'b1; rs = 5'd9;
    step();
    valid = 3'b111;
    rv    = 1'b0;
    #1;
    chk("pre_rst_we",    o_write_enable, 1'b1);
    chk("pre_rst_pend",  o_pending, 32'h208);
    chk("pre_rst_ptr2",  o_req_ready, 3'b100);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", o_req_ready, 3'b000);
    chk("mid_rst_we",    o_write_enable, 1'b0);
    chk("mid_rst_sel",   o_write_select, 5'd0);
    chk("mid_rst_data",  o_write_data, 32'h0);
    chk("mid_rst_pend",  o_pending, 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    step();
    chk("post_rst_ready", got_ready, 3'b001);

    // Random traffic against the behavioural model
    do_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_sel  = '0;
    m_data = '0;
    m_pend = '0;
    for (int c = 0; c < 600; c++) begin
      logic [2:0] exp_g;
      int gi;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!valid[k] && ($urandom_range(0, 1) == 1)) begin
          valid[k] = 1'b1;
          rsel[k]  = 5'($urandom_range(0, 31));
          rdat[k]  = $urandom;
        end
      end
      rv = 1'($urandom_range(0, 1));
      rs = 5'($urandom_range(0, 31));

      exp_g = '0;
      gi    = -1;
      for (int off = 0; off < 3; off++) begin
        int k;
        k = (m_ptr + off) % 3;
        if (gi < 0 && valid[k]) gi = k;
      end
      if (gi >= 0) exp_g[gi] = 1'b1;

      step();
      chk("rand_ready", got_ready, exp_g);

      if (gi >= 0) begin
        m_ptr  = (gi + 1) % 3;
        m_sel  = rsel[gi];
        m_data = rdat[gi];
        m_we   = (rsel[gi] != 0);
        m_pend[rsel[gi]] = 1'b0;
        valid[gi] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (rv && rs != 0) m_pend[rs] = 1'b1;
      m_pend[0] = 1'b0;

      chk("rand_we",   o_write_enable, m_we);
      chk("rand_sel",  o_write_select, m_sel);
      chk("rand_data", o_write_data, m_data);
      chk("rand_pend", o_pending, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the register bank among `NUM_REQ` write-back sources (ALU, load unit, multiplier) using round-robin arbitration with a valid/ready handshake. It holds a registered output stage that drives the bank's write-enable, write-select and write-data inputs. It also keeps a pending-write scoreboard (one bit per register) so the issue stage can detect read-after-write hazards. It sits between the execute/memory units and the register bank.

## Interface
- `DATA_WIDTH`, default 32: register data width; must match the bank.
- `NUM_REG`, default 32: number of architectural registers; must match the bank.
- `NUM_REQ`, default 3: number of write-back requesters; minimum 1.
- `SELECT_WIDTH`, localparam: `$clog2(NUM_REG)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req_valid`  in  [NUM_REQ]  requester k has a write pending.
- `i_req_select`  in  [NUM_REQ][SELECT_WIDTH]  destination register per requester.
- `i_req_data`  in  [NUM_REQ][DATA_WIDTH]  write data per requester.
- `o_req_ready`  out  [NUM_REQ]  one-hot grant; transfer occurs when `valid & ready`.
- `i_reserve_valid`  in  1  issue stage has dispatched an instruction that will write `i_reserve_select`.
- `i_reserve_select`  in  SELECT_WIDTH  register being reserved.
- `o_pending`  out  [NUM_REG]  bit r = 1 while a write to register r is outstanding.
- `o_write_enable`  out  1  to the bank's write enable.
- `o_write_select`  out  SELECT_WIDTH  to the bank's write select.
- `o_write_data`  out  DATA_WIDTH  to the bank's write data.

## Operation
- Round-robin pointer `ptr`, range 0..NUM_REQ-1.
  - Each cycle, grant the first requester with `i_req_valid` set, searching from `ptr` upward with wrap-around.
  - At most one `o_req_ready` bit is set. All are 0 when no requester is valid.
- On a grant of requester g:
  - At the clock edge, `ptr` <= (g+1) mod NUM_REQ.
  - Without a grant, `ptr` holds.
- Output stage, loaded at the edge of a transfer:
  - `o_write_select` <= `i_req_select[g]` and `o_write_data` <= `i_req_data[g]`.
  - `o_write_enable` <= 1 only if that select != 0.
  - Without a transfer, `o_write_enable` <= 0; select and data hold their previous values.
- Writes to register 0 are granted and consumed, but never reach the bank.
- Requester rule: once `valid` is asserted, `select` and `data` stay stable until `ready` is seen. The arbiter does not check this.
- Scoreboard, updated at each edge:
  - Set `o_pending[i_reserve_select]` when `i_reserve_valid` is set and the select != 0.
  - Clear `o_pending[s]` on a transfer with select s.
  - Set and clear of the same register in the same cycle: set wins (a younger producer exists).
  - Reserving an already-pending register leaves it at 1. There is no count, so issue must stall on pending.
  - `o_pending[0]` is constant 0.
- Reset, asynchronous and legal mid-operation:
  - `ptr`=0, `o_write_enable`=0, `o_write_select`=0, `o_write_data`=0, `o_pending`=all 0.
  - Any in-flight output-stage write is dropped.
  - `o_req_ready` is all 0 while `rst` is high.

## Timing
- `o_req_ready` is combinational from `i_req_valid` and `ptr`. There is no combinational path from `i_req_select`/`i_req_data` to `o_req_ready`.
- Latency:
  - Transfer at edge N → `o_write_enable`=1 during cycle N+1.
  - The bank captures the value at edge N+1, so it is readable from the bank after edge N+1.
- `o_pending` falls at edge N, the same edge the output stage loads.
- Throughput: one transfer per cycle, sustained. Under continuous contention each valid requester waits at most NUM_REQ-1 cycles.
- The output stage has no backpressure: the bank always accepts.

## Test plan
- Single requester: requester 1 valid with select=5, data=0xDEADBEEF for 1 cycle.
  - Required: `o_req_ready`=3'b010 that cycle.
  - Next cycle: `o_write_enable`=1, `o_write_select`=5, `o_write_data`=0xDEADBEEF.
  - Following cycle: `o_write_enable`=0.
- Fairness: all 3 requesters held valid for 6 cycles from reset.
  - Required grant order: 0,1,2,0,1,2.
  - Each requester drops valid after its grant. Requester 0 re-asserts at cycle 3 and is then granted at cycle 3.
- x0 write: requester 2 with select=0, data=0x1234.
  - Required: ready asserted.
  - Next cycle: `o_write_enable`=0; the bank's register 0 stays readable as 0.
- Scoreboard: reserve reg 7.
  - Required: `o_pending[7]`=1 after the edge.
  - A transfer to reg 7 clears it at the same edge `o_write_enable` is loaded.
  - Simultaneous reserve(7) and transfer(7): `o_pending[7]` stays 1.
- Reserve of reg 0 → `o_pending` stays all 0.
- Reset mid-operation:
  - With `o_write_enable`=1, `ptr`=2 and pending bits 3 and 9 set, pulse `rst` asynchronously between edges.
  - Required: all outputs 0 immediately.
  - After release, with all requesters valid, the first grant goes to requester 0.
